// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions.
// Contents: datapath widths, base opcodes, the 4-bit ALU operation enum,
// decode FSM states, the decode bundle types and two small decode helpers.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_LATCH, ST_VALID} state_t;

  typedef struct packed {
    alu_op_t alu;
    logic    use_imm;
    logic    reg_we;
    logic    mem_re;
    logic    mem_we;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } bundle_t;

  function automatic logic opcode_known(input logic [6:0] opc);
    return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                       OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
  endfunction

  // alt selects SUB (funct3=000) or SRA (funct3=101); callers decide when it applies.
  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle around the decode stage: fetch handshake, regFile read port,
// flush, and the decode-bundle handshake towards execute.
// Modports: slave = decode stage view, master = surrounding pipeline view.
interface decode_stage_if;
  import rv32i_pkg::*;

  logic              flush;
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_instr;
  logic [XLEN-1:0]   if_pc;
  logic [REG_AW-1:0] rf_rs1;
  logic [REG_AW-1:0] rf_rs2;
  logic              rf_wen;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_op1;
  logic [XLEN-1:0]   id_op2;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rd;
  alu_op_t           id_alu_op;
  logic              id_use_imm;
  logic              id_reg_we;
  logic              id_mem_re;
  logic              id_mem_we;
  logic              id_branch;
  logic              id_jump;
  logic              id_illegal;

  modport slave (
    input  flush, if_valid, if_instr, if_pc, rf_wen, rf_rd1, rf_rd2, id_ready,
    output if_ready, rf_rs1, rf_rs2, id_valid, id_pc, id_op1, id_op2, id_imm, id_rd,
           id_alu_op, id_use_imm, id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump,
           id_illegal
  );

  modport master (
    output flush, if_valid, if_instr, if_pc, rf_wen, rf_rd1, rf_rd2, id_ready,
    input  if_ready, rf_rs1, rf_rs2, id_valid, id_pc, id_op1, id_op2, id_imm, id_rd,
           id_alu_op, id_use_imm, id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump,
           id_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
// Ports: instr (in, 32) instruction word; imm (out, 32) sign-extended
// immediate in the format implied by the opcode, 0 for R-type/unknown.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage in front of a registered-read regFile.
// Ports: clk, rst (sync, active high); bus (decode_stage_if.slave) carrying
// flush, fetch handshake (if_*), regFile read port (rf_*) and the registered
// decode bundle handshake towards execute (id_*).
// One instruction in flight: IDLE -> READ (wait for a regFile read cycle,
// i.e. rf_wen low) -> LATCH (capture operands + decode) -> VALID.
module decode_stage
  import rv32i_pkg::*;
(
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  state_t            state_reg, state_next;
  logic [XLEN-1:0]   instr_reg, pc_reg;
  bundle_t           bundle_reg;
  ctrl_t             ctrl;
  logic [XLEN-1:0]   imm;
  logic              accept, legal, wb;
  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign funct3 = instr_reg[14:12];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign funct7 = instr_reg[31:25];

  imm_gen u_imm_gen (.instr(instr_reg), .imm(imm));

  assign bus.if_ready = !rst && (state_reg == ST_IDLE || (state_reg == ST_VALID && bus.id_ready));
  // flush suppresses the fetch handshake even though if_ready may be high
  assign accept = bus.if_valid && bus.if_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (accept) state_next = ST_READ;
        // regFile only refreshes its read outputs on edges where wEn is low
        ST_READ:  if (!bus.rf_wen) state_next = ST_LATCH;
        ST_LATCH: state_next = ST_VALID;
        ST_VALID: if (bus.id_ready) state_next = accept ? ST_READ : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.id_valid = (state_reg == ST_VALID);
    bus.rf_rs1   = rs1;
    bus.rf_rs2   = rs2;
  end

  assign legal = (instr_reg[1:0] == 2'b11) && opcode_known(opcode);

  always_comb begin
    ctrl = '0;
    wb   = 1'b0;
    if (!legal) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI:    begin ctrl.alu = ALU_PASSB; ctrl.use_imm = 1'b1; wb = 1'b1; end
        OPC_AUIPC:  begin ctrl.use_imm = 1'b1; wb = 1'b1; end
        OPC_JAL:    begin ctrl.jump = 1'b1; wb = 1'b1; end
        OPC_JALR:   begin ctrl.jump = 1'b1; ctrl.use_imm = 1'b1; wb = 1'b1; end
        OPC_BRANCH: begin ctrl.alu = ALU_SUB; ctrl.branch = 1'b1; end
        OPC_LOAD:   begin ctrl.use_imm = 1'b1; ctrl.mem_re = 1'b1; wb = 1'b1; end
        OPC_STORE:  begin ctrl.use_imm = 1'b1; ctrl.mem_we = 1'b1; end
        // no SUBI exists; SRAI is selected by imm[10]
        OPC_OP_IMM: begin
          ctrl.alu     = alu_from_funct(funct3, (funct3 == 3'b101) && instr_reg[30]);
          ctrl.use_imm = 1'b1;
          wb           = 1'b1;
        end
        OPC_OP: begin
          ctrl.alu = alu_from_funct(funct3, funct7 == 7'b0100000);
          wb       = 1'b1;
        end
        default: ctrl = '0;  // FENCE / SYSTEM: no enables
      endcase
    end
    ctrl.reg_we = wb && (rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg  <= '0;
      pc_reg     <= '0;
      bundle_reg <= '0;
    end else begin
      if (accept) begin
        instr_reg <= bus.if_instr;
        pc_reg    <= bus.if_pc;
      end
      if (state_reg == ST_LATCH && !bus.flush) begin
        bundle_reg.pc   <= pc_reg;
        bundle_reg.op1  <= (rs1 == '0) ? '0 : bus.rf_rd1;
        bundle_reg.op2  <= (rs2 == '0) ? '0 : bus.rf_rd2;
        bundle_reg.imm  <= imm;
        bundle_reg.rd   <= rd;
        bundle_reg.ctrl <= ctrl;
      end
    end
  end

  assign bus.id_pc      = bundle_reg.pc;
  assign bus.id_op1     = bundle_reg.op1;
  assign bus.id_op2     = bundle_reg.op2;
  assign bus.id_imm     = bundle_reg.imm;
  assign bus.id_rd      = bundle_reg.rd;
  assign bus.id_alu_op  = bundle_reg.ctrl.alu;
  assign bus.id_use_imm = bundle_reg.ctrl.use_imm;
  assign bus.id_reg_we  = bundle_reg.ctrl.reg_we;
  assign bus.id_mem_re  = bundle_reg.ctrl.mem_re;
  assign bus.id_mem_we  = bundle_reg.ctrl.mem_we;
  assign bus.id_branch  = bundle_reg.ctrl.branch;
  assign bus.id_jump    = bundle_reg.ctrl.jump;
  assign bus.id_illegal = bundle_reg.ctrl.illegal;

endmodule
